// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive buffer: default data length and
// the one-hot sequencer state encoding.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_LEN = 8;

  localparam int NUM_STATES    = 4;
  localparam int S_IDLE_IDX    = 0;
  localparam int S_ARM_IDX     = 1;
  localparam int S_WAIT_RI_IDX = 2;
  localparam int S_CAPTURE_IDX = 3;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE    = NUM_STATES'(1 << S_IDLE_IDX),
    S_ARM     = NUM_STATES'(1 << S_ARM_IDX),
    S_WAIT_RI = NUM_STATES'(1 << S_WAIT_RI_IDX),
    S_CAPTURE = NUM_STATES'(1 << S_CAPTURE_IDX)
  } state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver handshake plus MCU read port of the UART receive buffer.
// The master modport is the buffer itself; slave is the receiver/bus side.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_LEN,
  parameter int DEPTH      = 16
) ();

  logic                         rx_enable;
  logic                         start_RX;
  logic                         RI;
  logic [DATA_WIDTH-1:0]        SBUF_in;
  logic                         rd_en;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         rd_valid;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic                         empty;
  logic                         full;
  logic                         overrun;
  logic                         overrun_clr;
  logic                         data_irq;

  modport master (
    input  rx_enable, RI, SBUF_in, rd_en, overrun_clr,
    output start_RX, rd_data, rd_valid, fifo_count, empty, full, overrun, data_irq
  );

  modport slave (
    output rx_enable, RI, SBUF_in, rd_en, overrun_clr,
    input  start_RX, rd_data, rd_valid, fifo_count, empty, full, overrun, data_irq
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo_1clk.sv
// Single-clock FIFO with registered pop port; a write into a full FIFO is
// accepted only when a pop frees the head entry in the same cycle.
module sync_fifo_1clk
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_LEN,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       wr_ok,
  input  logic                       rd_en,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  rd_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pop reads the old head before this cycle's write lands, so a
  // simultaneous push never bypasses into rd_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: re-arms the receiver after every frame, stores each
// received byte and exposes occupancy, level interrupt and sticky overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_LEN,
  parameter int DEPTH      = 16,
  parameter int IRQ_LEVEL  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sync_reset,
  uart_rx_fifo_if.master bus
);

  localparam int              CW         = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   IRQ_THRESH = CW'(IRQ_LEVEL);

  state_t state;
  state_t state_next;
  logic   push;
  logic   wr_ok;

  sync_fifo_1clk #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (sync_reset),
    .wr_en    (push),
    .wr_data  (bus.SBUF_in),
    .wr_ok    (wr_ok),
    .rd_en    (bus.rd_en),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid),
    .count    (bus.fifo_count),
    .empty    (bus.empty),
    .full     (bus.full)
  );

  assign bus.data_irq = (bus.fifo_count >= IRQ_THRESH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (sync_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Once armed, a frame always runs to capture; rx_enable only decides
  // whether the next frame gets armed.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      S_IDLE:    if (bus.rx_enable) state_next = S_ARM;
      S_ARM:     state_next = S_WAIT_RI;
      S_WAIT_RI: if (bus.RI) state_next = S_CAPTURE;
      S_CAPTURE: begin
        push       = 1'b1;
        state_next = bus.rx_enable ? S_ARM : S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // start_RX is registered so it is high exactly while the FSM sits in S_ARM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.start_RX <= 1'b0;
      bus.overrun  <= 1'b0;
    end else if (sync_reset) begin
      bus.start_RX <= 1'b0;
      bus.overrun  <= 1'b0;
    end else begin
      bus.start_RX <= (state_next == S_ARM);
      if (push && !wr_ok) begin
        bus.overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_rx_fifo;

  localparam int DW        = 8;
  localparam int DEPTH     = 16;
  localparam int IRQ_LEVEL = 1;

  logic clk        = 1'b0;
  logic reset_n    = 1'b0;
  logic sync_reset = 1'b0;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .IRQ_LEVEL  (IRQ_LEVEL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int total       = 0;
  int bad         = 0;
  int cycle       = 0;
  int start_count = 0;
  bit armed       = 1'b0;

  // Reference model: receiver-handshake phase plus a byte queue.
  typedef enum {M_IDLE, M_ARM, M_LISTEN, M_TAKE} mphase_t;
  mphase_t       m_phase    = M_IDLE;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data  = '0;
  bit            m_rd_valid = 1'b0;
  bit            m_ovr      = 1'b0;
  bit            m_start    = 1'b0;
  bit            m_rd_ok;
  bit            m_drop;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h cycle=%0d", name, actual, expected, cycle);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_phase    = M_IDLE;
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovr      = 1'b0;
    m_start    = 1'b0;
  endtask

  always @(posedge clk) begin
    if (!reset_n || sync_reset) begin
      model_clear();
    end else begin
      m_rd_ok = bus.rd_en && (q.size() > 0);
      m_drop  = 1'b0;
      if (m_rd_ok) m_rd_data = q.pop_front();
      m_rd_valid = m_rd_ok;
      if (m_phase == M_TAKE) begin
        if (q.size() < DEPTH) q.push_back(bus.SBUF_in);
        else m_drop = 1'b1;
      end
      if (m_drop) m_ovr = 1'b1;
      else if (bus.overrun_clr) m_ovr = 1'b0;
      case (m_phase)
        M_IDLE:   if (bus.rx_enable) m_phase = M_ARM;
        M_ARM:    m_phase = M_LISTEN;
        M_LISTEN: if (bus.RI) m_phase = M_TAKE;
        M_TAKE:   m_phase = bus.rx_enable ? M_ARM : M_IDLE;
        default:  m_phase = M_IDLE;
      endcase
      m_start = (m_phase == M_ARM);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check_output("start_RX",   int'(bus.start_RX),   int'(m_start));
      check_output("rd_valid",   int'(bus.rd_valid),   int'(m_rd_valid));
      check_output("rd_data",    int'(bus.rd_data),    int'(m_rd_data));
      check_output("fifo_count", int'(bus.fifo_count), q.size());
      check_output("empty",      int'(bus.empty),      int'(q.size() == 0));
      check_output("full",       int'(bus.full),       int'(q.size() == DEPTH));
      check_output("overrun",    int'(bus.overrun),    int'(m_ovr));
      check_output("data_irq",   int'(bus.data_irq),   int'(q.size() >= IRQ_LEVEL));
    end
  end

  // One clock; the receiver clears RI at the edge where it sees start_RX.
  task automatic tick();
    logic s;
    s = bus.start_RX;
    @(posedge clk);
    #1;
    cycle++;
    if (s === 1'b1) begin
      bus.RI = 1'b0;
      armed  = 1'b1;
      start_count++;
    end
  endtask

  task automatic apply_stimulus(input logic rx_en, input logic rd, input logic oclr);
    bus.rx_enable   = rx_en;
    bus.rd_en       = rd;
    bus.overrun_clr = oclr;
    tick();
  endtask

  // Returns in the capture cycle (the one after RI was first high).
  task automatic send_frame(input logic [DW-1:0] d);
    int n;
    n = 0;
    while (!armed && n < 60) begin
      tick();
      n++;
    end
    if (!armed) begin
      check_output("arm_timeout", 0, 1);
    end else begin
      bus.SBUF_in = d;
      bus.RI      = 1'b1;
      armed       = 1'b0;
      tick();
    end
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) send_frame(DW'(base + i));
    tick();
    tick();
  endtask

  task automatic drain(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      bus.rd_en = 1'b1;
      tick();
      check_output("drain_data", int'(bus.rd_data), (first + i) & 8'hFF);
    end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got=running expected=finished cycle=%0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    int rd_prob;
    bus.rx_enable   = 1'b0;
    bus.RI          = 1'b0;
    bus.SBUF_in     = '0;
    bus.rd_en       = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check_output("rst_count",   int'(bus.fifo_count), 0);
    check_output("rst_empty",   int'(bus.empty),      1);
    check_output("rst_full",    int'(bus.full),       0);
    check_output("rst_start",   int'(bus.start_RX),   0);
    check_output("rst_rd_data", int'(bus.rd_data),    0);
    check_output("rst_irq",     int'(bus.data_irq),   0);

    // Single byte round trip
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("arm_pulse_hi", int'(bus.start_RX), 1);
    tick();
    check_output("arm_pulse_lo", int'(bus.start_RX), 0);
    send_frame(8'hA5);
    tick();
    check_output("one_count", int'(bus.fifo_count), 1);
    check_output("one_irq",   int'(bus.data_irq),   1);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("pop_data",  int'(bus.rd_data),  8'hA5);
    check_output("pop_valid", int'(bus.rd_valid), 1);
    check_output("pop_empty", int'(bus.empty),    1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("pop_valid_lo", int'(bus.rd_valid), 0);

    // Fill to full, overrun on the 17th byte, drain in order across wrap
    fill(8'h00, 16);
    check_output("full_count",   int'(bus.fifo_count), 16);
    check_output("full_flag",    int'(bus.full),       1);
    check_output("full_no_ovr",  int'(bus.overrun),    0);
    send_frame(8'hFF);
    tick();
    check_output("ovr_set",      int'(bus.overrun),    1);
    check_output("ovr_count",    int'(bus.fifo_count), 16);
    drain(16, 8'h00);
    check_output("drained_empty", int'(bus.empty), 1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    bus.overrun_clr = 1'b0;
    check_output("ovr_cleared", int'(bus.overrun), 0);

    // Full FIFO with a pop in the capture cycle
    fill(8'h00, 16);
    send_frame(8'h10);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_output("rw_count",   int'(bus.fifo_count), 16);
    check_output("rw_no_ovr",  int'(bus.overrun),    0);
    check_output("rw_rd_data", int'(bus.rd_data),    8'h00);
    drain(16, 8'h01);

    // Pop on empty is ignored
    apply_stimulus(1'b1, 1'b1, 1'b0);
    bus.rd_en = 1'b0;
    check_output("empty_pop_valid", int'(bus.rd_valid), 0);
    check_output("empty_pop_data",  int'(bus.rd_data),  8'h10);

    // Overrun set wins over a same-cycle clear; clear alone works
    fill(8'h20, 16);
    send_frame(8'hEE);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    check_output("set_beats_clr", int'(bus.overrun), 1);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    bus.overrun_clr = 1'b0;
    check_output("clr_alone", int'(bus.overrun), 0);
    send_frame(8'hEF);
    tick();
    check_output("ovr_again", int'(bus.overrun), 1);
    drain(11, 8'h20);
    check_output("five_count", int'(bus.fifo_count), 5);
    check_output("five_ovr",   int'(bus.overrun),    1);

    // Synchronous clear
    bus.rx_enable = 1'b0;
    sync_reset    = 1'b1;
    tick();
    sync_reset = 1'b0;
    armed      = 1'b0;
    bus.RI     = 1'b0;
    check_output("srst_count", int'(bus.fifo_count), 0);
    check_output("srst_empty", int'(bus.empty),      1);
    check_output("srst_ovr",   int'(bus.overrun),    0);
    check_output("srst_start", int'(bus.start_RX),   0);
    snap        = start_count;
    bus.SBUF_in = 8'h77;
    bus.RI      = 1'b1;
    repeat (4) tick();
    bus.RI = 1'b0;
    check_output("srst_idle_count", int'(bus.fifo_count), 0);
    check_output("srst_idle_arms",  start_count, snap);

    // rx_enable dropped while waiting for a frame
    bus.rx_enable = 1'b1;
    for (int i = 0; i < 10 && !armed; i++) tick();
    bus.rx_enable = 1'b0;
    send_frame(8'h3C);
    snap = start_count;
    repeat (6) tick();
    check_output("drop_en_count", int'(bus.fifo_count), 1);
    check_output("drop_en_arms",  start_count, snap);
    drain(1, 8'h3C);

    // Random traffic, alternating slow and fast readers
    bus.rx_enable = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      rd_prob = (seg % 2 == 0) ? 12 : 60;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 24) == 0) bus.rx_enable = ~bus.rx_enable;
        bus.rd_en       = ($urandom_range(0, 99) < rd_prob);
        bus.overrun_clr = ($urandom_range(0, 15) == 0);
        sync_reset      = ($urandom_range(0, 399) == 0);
        if (sync_reset) begin
          bus.RI = 1'b0;
        end else if (armed && !bus.RI && $urandom_range(0, 2) == 0) begin
          bus.SBUF_in = DW'($urandom);
          bus.RI      = 1'b1;
          armed       = 1'b0;
        end
        tick();
        if (sync_reset) armed = 1'b0;
      end
    end
    sync_reset      = 1'b0;
    bus.rd_en       = 1'b0;
    bus.overrun_clr = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
